// File: rtl/timer_ctrl_pkg.sv
// Shared types and constants for the countdown timer sequencing controller.
package timer_ctrl_pkg;

  localparam int DIGIT_W    = 4;
  localparam int NUM_DIGITS = 4;
  localparam int DATA_W     = DIGIT_W * NUM_DIGITS;

  localparam logic [DIGIT_W-1:0] MAX_DIGIT    = 4'd9;
  localparam logic [DIGIT_W-1:0] MAX_SEC_TENS = 4'd5;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    RUNNING = 3'd2,
    PAUSED  = 3'd3,
    DONE    = 3'd4
  } state_e;

  // A preset is startable when it is non-zero and its seconds-tens digit is a real MOD6 value.
  function automatic logic preset_ok(input logic [DATA_W-1:0] preset);
    return (preset != '0) && (preset[2*DIGIT_W-1:DIGIT_W] <= MAX_SEC_TENS);
  endfunction

endpackage

// File: rtl/timer_controller_prescaler.sv
// Tick prescaler: counts 0..CLK_DIV-1 while run is high, holds otherwise; restart zeroes it.
module tick_prescaler #(
  parameter int CLK_DIV = 4
) (
  input  logic clock,
  input  logic clr,
  input  logic run_i,
  input  logic restart_i,
  output logic wrap_o
);

  localparam int                CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    // NOTE: default assignment first so every path drives cnt_d and no latch is inferred.
    cnt_d = cnt_q;
    if (restart_i) begin
      cnt_d = '0;
    end else if (run_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignment so all flops update together at the edge.
  always_ff @(posedge clock or posedge clr) begin
    if (clr) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign wrap_o = run_i && !restart_i && (cnt_q == LAST);

endmodule

// File: rtl/timer_controller.sv
// Countdown timer sequencing controller: keypad preset, load/run/pause/done FSM, tick enable, heat drive.
// Optional door interlock compiled in with `define DOOR_INTERLOCK_EN.
module timer_controller
  import timer_ctrl_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic              clock,
  input  logic              clr,
  input  logic              keypad_valid,
  input  logic [DIGIT_W-1:0] keypad_digit,
  input  logic              start,
  input  logic              stop,
  input  logic              cancel,
  input  logic              door_open,
  input  logic              timer_zero,
  output logic [DATA_W-1:0] timer_data,
  output logic              timer_loadn,
  output logic              timer_clrn,
  output logic              timer_enable,
  output logic              heat_on,
  output logic              done,
  output logic              err
);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                loadn_q, clrn_q, enable_q, heat_q, done_q, err_q;
  logic                err_d, enable_d, clear_chain;
  logic                run, restart, wrap;
  logic                door_block;

`ifdef DOOR_INTERLOCK_EN
  assign door_block = door_open;
`else
  logic unused_door_open;
  assign unused_door_open = door_open;
  assign door_block       = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    err_d       = 1'b0;
    clear_chain = 1'b0;
    if (cancel) begin
      state_d     = IDLE;
      clear_chain = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && !stop) begin
            if (!preset_ok(data_q) || door_block) begin
              err_d = 1'b1;
            end else begin
              state_d = LOAD;
            end
          end else if (!start && !stop && keypad_valid && (keypad_digit <= MAX_DIGIT)) begin
            data_d = {data_q[DATA_W-DIGIT_W-1:0], keypad_digit};
          end
        end
        LOAD: state_d = RUNNING;
        RUNNING: begin
          if (stop || door_block) begin
            state_d = PAUSED;
          end else if (timer_zero) begin
            state_d = DONE;
          end
        end
        PAUSED: begin
          if (stop) begin
            state_d     = IDLE;
            clear_chain = 1'b1;
          end else if (start && !door_block) begin
            state_d = RUNNING;
          end
        end
        DONE: begin
          if (start || stop) begin
            state_d     = IDLE;
            clear_chain = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    if (clear_chain) begin
      data_d = '0;
    end
  end

  // The prescaler only advances on cycles that stay in RUNNING, so a pause freezes it mid-count.
  assign run      = (state_q == RUNNING) && (state_d == RUNNING);
  assign restart  = (state_d == LOAD);
  assign enable_d = wrap && !timer_zero;

  tick_prescaler #(
    .CLK_DIV (CLK_DIV)
  ) u_prescaler (
    .clock     (clock),
    .clr       (clr),
    .run_i     (run),
    .restart_i (restart),
    .wrap_o    (wrap)
  );

  always_ff @(posedge clock or posedge clr) begin
    if (clr) begin
      state_q  <= IDLE;
      data_q   <= '0;
      loadn_q  <= 1'b1;
      clrn_q   <= 1'b0;
      enable_q <= 1'b0;
      heat_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      loadn_q  <= (state_d != LOAD);
      clrn_q   <= !clear_chain;
      enable_q <= enable_d;
      heat_q   <= (state_d == RUNNING);
      done_q   <= (state_d == DONE);
      err_q    <= err_d;
    end
  end

  assign timer_data   = data_q;
  assign timer_loadn  = loadn_q;
  assign timer_clrn   = clrn_q;
  assign timer_enable = enable_q;
  assign heat_on      = heat_q;
  assign done         = done_q;
  assign err          = err_q;

endmodule

// File: tb/tb_timer_controller.sv
// Directed, table-driven bench for timer_controller (CLK_DIV=4), plus hand-written clr sequence.
module tb_timer_controller;

  logic        clock = 1'b0;
  logic        clr = 1'b0;
  logic        keypad_valid = 1'b0;
  logic [3:0]  keypad_digit = 4'd0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        cancel = 1'b0;
  logic        door_open = 1'b0;
  logic        timer_zero = 1'b0;
  logic [15:0] timer_data;
  logic        timer_loadn, timer_clrn, timer_enable, heat_on, done, err;

  int checks = 0;
  int failures = 0;

  timer_controller #(.CLK_DIV(4)) dut (
    .clock        (clock),
    .clr          (clr),
    .keypad_valid (keypad_valid),
    .keypad_digit (keypad_digit),
    .start        (start),
    .stop         (stop),
    .cancel       (cancel),
    .door_open    (door_open),
    .timer_zero   (timer_zero),
    .timer_data   (timer_data),
    .timer_loadn  (timer_loadn),
    .timer_clrn   (timer_clrn),
    .timer_enable (timer_enable),
    .heat_on      (heat_on),
    .done         (done),
    .err          (err)
  );

  always #5 clock = ~clock;

  logic [21:0] dut_outs;
  assign dut_outs = {timer_data, timer_loadn, timer_clrn, timer_enable, heat_on, done, err};

  typedef struct {
    logic        kv;
    logic [3:0]  kd;
    logic        st, sp, cn, dr, tz;
    logic [15:0] data;
    logic        loadn, clrn, en, heat, dn, er;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic kv, input logic [3:0] kd, input logic st, input logic sp,
                     input logic cn, input logic dr, input logic tz, input logic [15:0] data,
                     input logic loadn, input logic clrn, input logic en, input logic heat,
                     input logic dn, input logic er);
    vec_t v;
    v.kv = kv; v.kd = kd; v.st = st; v.sp = sp; v.cn = cn; v.dr = dr; v.tz = tz;
    v.data = data; v.loadn = loadn; v.clrn = clrn; v.en = en; v.heat = heat; v.dn = dn; v.er = er;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [21:0] act, input logic [21:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got data=%h loadn=%b clrn=%b en=%b heat=%b done=%b err=%b, expected data=%h loadn=%b clrn=%b en=%b heat=%b done=%b err=%b",
               name, act[21:6], act[5], act[4], act[3], act[2], act[1], act[0],
               exp[21:6], exp[5], exp[4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    // kv kd st sp cn dr tz | data loadn clrn en heat done err
    add(0,0, 0,0,0,0,0, 16'h0000, 1,1,0,0,0,0);  // idle after reset release
    add(1,0, 0,0,0,0,0, 16'h0000, 1,1,0,0,0,0);
    add(1,1, 0,0,0,0,0, 16'h0001, 1,1,0,0,0,0);
    add(1,3, 0,0,0,0,0, 16'h0013, 1,1,0,0,0,0);
    add(1,0, 0,0,0,0,0, 16'h0130, 1,1,0,0,0,0);
    add(1,12,0,0,0,0,0, 16'h0130, 1,1,0,0,0,0);  // digit >9 ignored
    add(0,0, 1,0,0,0,0, 16'h0130, 0,1,0,0,0,0);  // start -> LOAD
    add(0,0, 0,0,0,0,0, 16'h0130, 1,1,0,1,0,0);  // RUNNING, cnt 0
    add(0,0, 0,0,0,0,0, 16'h0130, 1,1,0,1,0,0);
    add(0,0, 0,0,0,0,0, 16'h0130, 1,1,0,1,0,0);
    add(0,0, 0,0,0,0,0, 16'h0130, 1,1,0,1,0,0);
    add(0,0, 0,0,0,0,0, 16'h0130, 1,1,1,1,0,0);  // first enable, 5 edges after start
    add(0,0, 0,0,0,0,0, 16'h0130, 1,1,0,1,0,0);
    add(0,0, 0,0,0,0,0, 16'h0130, 1,1,0,1,0,0);
    add(0,0, 0,0,0,0,0, 16'h0130, 1,1,0,1,0,0);
    add(0,0, 0,0,0,0,0, 16'h0130, 1,1,1,1,0,0);  // every 4 cycles
    add(0,0, 0,0,0,0,0, 16'h0130, 1,1,0,1,0,0);
    add(0,0, 0,0,0,0,0, 16'h0130, 1,1,0,1,0,0);  // cnt 2 now
    add(0,0, 0,1,0,0,0, 16'h0130, 1,1,0,0,0,0);  // stop -> PAUSED
    add(0,0, 0,0,0,0,0, 16'h0130, 1,1,0,0,0,0);
    add(0,0, 1,0,0,0,0, 16'h0130, 1,1,0,1,0,0);  // resume
    add(0,0, 0,0,0,0,0, 16'h0130, 1,1,0,1,0,0);
    add(0,0, 0,0,0,0,0, 16'h0130, 1,1,1,1,0,0);  // enable after remaining 2 cycles
    add(0,0, 0,0,0,0,0, 16'h0130, 1,1,0,1,0,0);
    add(0,0, 0,1,0,0,0, 16'h0130, 1,1,0,0,0,0);  // stop -> PAUSED
    add(0,0, 1,1,0,0,0, 16'h0000, 1,0,0,0,0,0);  // start+stop in PAUSED: stop -> IDLE, clear
    add(0,0, 0,0,0,0,0, 16'h0000, 1,1,0,0,0,0);
    add(1,0, 0,0,0,0,0, 16'h0000, 1,1,0,0,0,0);
    add(1,0, 0,0,0,0,0, 16'h0000, 1,1,0,0,0,0);
    add(1,7, 0,0,0,0,0, 16'h0007, 1,1,0,0,0,0);
    add(1,0, 0,0,0,0,0, 16'h0070, 1,1,0,0,0,0);
    add(0,0, 1,0,0,0,0, 16'h0070, 1,1,0,0,0,1);  // seconds tens 7 rejected
    add(0,0, 0,0,0,0,0, 16'h0070, 1,1,0,0,0,0);
    add(0,0, 0,0,1,0,0, 16'h0000, 1,0,0,0,0,0);  // cancel in IDLE
    add(0,0, 1,0,0,0,0, 16'h0000, 1,1,0,0,0,1);  // zero preset rejected
    add(0,0, 1,1,0,0,0, 16'h0000, 1,1,0,0,0,0);  // start+stop in IDLE: no err
    add(1,5, 0,0,0,0,0, 16'h0005, 1,1,0,0,0,0);
    add(1,9, 0,0,0,0,0, 16'h0059, 1,1,0,0,0,0);
    add(0,0, 1,0,0,0,0, 16'h0059, 0,1,0,0,0,0);  // tens=5 accepted
    add(0,0, 0,0,0,0,0, 16'h0059, 1,1,0,1,0,0);
    add(1,7, 0,0,0,0,0, 16'h0059, 1,1,0,1,0,0);  // keypad ignored while running
    add(0,0, 0,0,0,0,0, 16'h0059, 1,1,0,1,0,0);
    add(0,0, 0,0,0,0,0, 16'h0059, 1,1,0,1,0,0);
    add(0,0, 0,0,0,0,1, 16'h0059, 1,1,0,0,1,0);  // zero at wrap: DONE, enable suppressed
    add(0,0, 0,0,0,0,1, 16'h0059, 1,1,0,0,1,0);
    add(1,3, 0,0,0,0,1, 16'h0059, 1,1,0,0,1,0);  // keypad ignored in DONE
    add(0,0, 1,0,0,0,0, 16'h0000, 1,0,0,0,0,0);  // start leaves DONE with clear
    add(0,0, 0,0,0,0,0, 16'h0000, 1,1,0,0,0,0);
    add(1,1, 0,0,0,0,0, 16'h0001, 1,1,0,0,0,0);
    add(0,0, 1,0,0,0,0, 16'h0001, 0,1,0,0,0,0);
    add(0,0, 0,0,0,0,0, 16'h0001, 1,1,0,1,0,0);
    add(0,0, 1,0,1,0,0, 16'h0000, 1,0,0,0,0,0);  // cancel beats start
    add(0,0, 0,0,0,0,0, 16'h0000, 1,1,0,0,0,0);
`ifdef DOOR_INTERLOCK_EN
    add(1,2, 0,0,0,0,0, 16'h0002, 1,1,0,0,0,0);
    add(0,0, 1,0,0,1,0, 16'h0002, 1,1,0,0,0,1);  // door open blocks start
    add(0,0, 1,0,0,0,0, 16'h0002, 0,1,0,0,0,0);
    add(0,0, 0,0,0,0,0, 16'h0002, 1,1,0,1,0,0);
    add(0,0, 0,0,0,1,0, 16'h0002, 1,1,0,0,0,0);  // door opens -> PAUSED
    add(0,0, 1,0,0,1,0, 16'h0002, 1,1,0,0,0,0);  // resume blocked, no err
    add(0,0, 0,0,0,0,0, 16'h0002, 1,1,0,0,0,0);
    add(0,0, 1,0,0,0,0, 16'h0002, 1,1,0,1,0,0);  // door closed, resume
    add(0,0, 0,0,0,0,0, 16'h0002, 1,1,0,1,0,0);
    add(0,0, 0,0,0,0,0, 16'h0002, 1,1,0,1,0,0);
    add(0,0, 0,0,0,0,0, 16'h0002, 1,1,0,1,0,0);
    add(0,0, 0,0,0,0,0, 16'h0002, 1,1,1,1,0,0);
    add(0,0, 0,0,1,0,0, 16'h0000, 1,0,0,0,0,0);
    add(0,0, 0,0,0,0,0, 16'h0000, 1,1,0,0,0,0);
`else
    add(1,2, 0,0,0,0,0, 16'h0002, 1,1,0,0,0,0);
    add(0,0, 1,0,0,1,0, 16'h0002, 0,1,0,0,0,0);  // door ignored at start
    add(0,0, 0,0,0,1,0, 16'h0002, 1,1,0,1,0,0);
    add(0,0, 0,0,0,1,0, 16'h0002, 1,1,0,1,0,0);  // door ignored while running
    add(0,0, 1,0,0,1,0, 16'h0002, 1,1,0,1,0,0);
    add(0,0, 0,0,0,1,0, 16'h0002, 1,1,0,1,0,0);
    add(0,0, 0,0,0,1,0, 16'h0002, 1,1,1,1,0,0);
    add(0,0, 0,0,1,0,0, 16'h0000, 1,0,0,0,0,0);
    add(0,0, 0,0,0,0,0, 16'h0000, 1,1,0,0,0,0);
`endif

    #1 clr = 1'b1;
    #1 check("reset", dut_outs, {16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    @(posedge clock); #1;
    check("reset_hold", dut_outs, {16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    #2 clr = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      keypad_valid = vecs[i].kv;
      keypad_digit = vecs[i].kd;
      start        = vecs[i].st;
      stop         = vecs[i].sp;
      cancel       = vecs[i].cn;
      door_open    = vecs[i].dr;
      timer_zero   = vecs[i].tz;
      @(posedge clock); #1;
      check($sformatf("vec%0d", i), dut_outs,
            {vecs[i].data, vecs[i].loadn, vecs[i].clrn, vecs[i].en,
             vecs[i].heat, vecs[i].dn, vecs[i].er});
    end
    keypad_valid = 1'b0; keypad_digit = 4'd0; start = 1'b0; stop = 1'b0;
    cancel = 1'b0; door_open = 1'b0; timer_zero = 1'b0;

    // Asynchronous clr while an enable is being driven.
    keypad_valid = 1'b1; keypad_digit = 4'd1;
    @(posedge clock); #1;
    keypad_valid = 1'b0; keypad_digit = 4'd0;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    check("clr_seq_load", dut_outs, {16'h0001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    repeat (5) @(posedge clock);
    #1 check("clr_seq_enable", dut_outs, {16'h0001, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
    #2 clr = 1'b1;
    #1 check("async_clr", dut_outs, {16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    @(posedge clock); #1;
    check("clr_held", dut_outs, {16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    clr = 1'b0;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    check("post_clr_start", dut_outs, {16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
